// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

  typedef enum logic {RUN, DIV_BUSY} hazard_state_t;

  localparam logic [31:0] NOP_INSTR          = 32'h00000013;
  localparam int          DEFAULT_DIV_CYCLES = 32;
  localparam int          DEFAULT_CNT_W      = 8;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detector: the instruction in ID reads the
// destination of a load that is still in EX, so forwarding cannot help.
module load_use_detector (
  input  logic [4:0] i_rs1_id,
  input  logic [4:0] i_rs2_id,
  input  logic       i_rs1_used_id,
  input  logic       i_rs2_used_id,
  input  logic [4:0] i_rd_ex,
  input  logic       i_mem_read_ex,
  output logic       o_lu
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never a real dependency, so rd_ex==0 never stalls.
  always_comb begin
    w_rs1_hit = i_rs1_used_id && (i_rs1_id == i_rd_ex);
    w_rs2_hit = i_rs2_used_id && (i_rs2_id == i_rd_ex);
    o_lu      = i_mem_read_ex && (i_rd_ex != 5'd0) && (w_rs1_hit || w_rs2_hit);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer for the 5-stage core: load-use stalls,
// taken-branch flushes and multi-cycle divide freeze.
// Optional macro HAZARD_PERF_CNT_EN adds saturating 32-bit stall/flush
// performance counters; control behaviour is identical either way.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic [4:0]  rd_ex,
  input  logic        mem_read_ex,
  input  logic        is_div_id,
  input  logic        branch_taken_ex,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        if_id_flush,
  output logic        div_start,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] load_stall_cnt,
  output logic [31:0] div_stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        div_busy
);

  hazard_state_t    r_state;
  hazard_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] w_div_cnt_nxt;
  logic             w_lu;

  load_use_detector u_lud (
    .i_rs1_id      (rs1_id),
    .i_rs2_id      (rs2_id),
    .i_rs1_used_id (rs1_used_id),
    .i_rs2_used_id (rs2_used_id),
    .i_rd_ex       (rd_ex),
    .i_mem_read_ex (mem_read_ex),
    .o_lu          (w_lu)
  );

  // State and divide-counter registers; reset aborts any divide in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_div_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
    end
  end

  // Next-state and pipeline control outputs, priority branch > load-use > divide.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if_id_flush   = 1'b0;
    div_start     = 1'b0;
    div_busy      = 1'b0;
    if (!reset) begin
      case (r_state)
        RUN: begin
          if (branch_taken_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_lu) begin
            // One bubble suffices: next cycle the load has moved to MEM.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (is_div_id) begin
            div_start     = 1'b1;
            w_state_nxt   = DIV_BUSY;
            w_div_cnt_nxt = CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_BUSY: begin
          // EX holds the divide, so branch/load-use/divide inputs are ignored.
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          div_busy      = 1'b1;
          w_div_cnt_nxt = r_div_cnt - CNT_W'(1);
          if (r_div_cnt == '0) begin
            // Result cycle: let the quotient into EX/MEM.
            ex_mem_bubble = 1'b0;
            w_state_nxt   = RUN;
            w_div_cnt_nxt = '0;
          end else begin
            ex_mem_bubble = 1'b1;
          end
        end
        default: begin
          w_state_nxt   = RUN;
          w_div_cnt_nxt = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_load_stall_cnt;
  logic [31:0] r_div_stall_cnt;
  logic [31:0] r_flush_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters for stall and flush profiling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_stall_cnt <= '0;
      r_div_stall_cnt  <= '0;
      r_flush_cnt      <= '0;
    end else begin
      if (r_state == RUN && w_lu && !branch_taken_ex)
        r_load_stall_cnt <= sat_inc(r_load_stall_cnt);
      if (r_state == DIV_BUSY)
        r_div_stall_cnt <= sat_inc(r_div_stall_cnt);
      if (r_state == RUN && branch_taken_ex)
        r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign load_stall_cnt = r_load_stall_cnt;
  assign div_stall_cnt  = r_div_stall_cnt;
  assign flush_cnt      = r_flush_cnt;
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline control sequencer for the 5-stage RISC-V core. Sits beside the forwarding logic and drives the PC, IF/ID, ID/EX and EX/MEM write-enables, bubbles and flushes.
- Resolves three hazards:
  - load-use stalls, which forwarding cannot cover;
  - taken-branch flushes;
  - multi-cycle divide occupancy. An internal FSM counts the divider's fixed latency while the front of the pipe is frozen.

Parameters:
- DIV_CYCLES, 32: cycles the iterative divider needs after div_start; legal range 2..255.
- CNT_W, 8: width of the divide cycle counter; must hold DIV_CYCLES-1.

Ports:
- clk, input, 1: core clock.
- reset, input, 1: synchronous, active-high reset.
- rs1_id, input, 5: rs1 of the instruction in ID.
- rs2_id, input, 5: rs2 of the instruction in ID.
- rs1_used_id, input, 1: ID instruction reads rs1.
- rs2_used_id, input, 1: ID instruction reads rs2.
- rd_ex, input, 5: destination register of the instruction in EX.
- mem_read_ex, input, 1: EX instruction is a load.
- is_div_id, input, 1: ID instruction is DIV/DIVU/REM/REMU.
- branch_taken_ex, input, 1: EX resolved a taken branch or jump.
- pc_write, output, 1: PC update enable.
- if_id_write, output, 1: IF/ID register enable.
- id_ex_write, output, 1: ID/EX register enable.
- id_ex_bubble, output, 1: load a NOP into ID/EX.
- ex_mem_bubble, output, 1: load a NOP into EX/MEM.
- if_id_flush, output, 1: clear IF/ID.
- div_start, output, 1: one-cycle start pulse to the divider.
- div_busy, output, 1: divide sequence in progress.

Behaviour:
- FSM states: RUN, DIV_BUSY. A CNT_W-bit down-counter div_cnt is used in DIV_BUSY.
- Reset (synchronous, takes priority over everything, including mid-divide):
  - state=RUN, div_cnt=0.
  - Outputs while reset is high: pc_write=1, if_id_write=1, id_ex_write=1; all others 0.
- Load-use condition (lu), combinational:
  - mem_read_ex && rd_ex!=0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)).
- RUN, priority order:
  1. branch_taken_ex:
     - if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1.
     - lu and is_div_id are ignored; no div_start.
  2. lu:
     - pc_write=0, if_id_write=0, id_ex_bubble=1.
     - Exactly one bubble per load. The next cycle the load is in MEM, so lu clears without extra state.
  3. is_div_id:
     - div_start=1 for exactly this cycle; the divide enters ID/EX normally.
     - Next state DIV_BUSY, div_cnt <= DIV_CYCLES-1.
  4. Otherwise: all enables 1, all bubbles/flushes 0.
- DIV_BUSY:
  - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, div_busy=1.
  - div_cnt decrements each cycle.
  - When div_cnt==0: this is the divider's result cycle. ex_mem_bubble=0, so the result enters EX/MEM; enables stay 0. Next state RUN.
  - branch_taken_ex, lu and is_div_id are ignored in DIV_BUSY, since EX holds the divide.
- Total front-end freeze per divide: DIV_CYCLES cycles after the start cycle.
- Back-to-back divides: the second divide waits in ID and starts on the first RUN cycle after the freeze. There is no gap cycle other than that RUN cycle.
- div_start is never asserted in DIV_BUSY or during reset.
- Only the listed outputs are driven. All outputs are combinational from state, div_cnt and inputs; only state and div_cnt are registered.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output ports load_stall_cnt, div_stall_cnt and flush_cnt, each 32 bits.
  - Each counter is saturating at 0xFFFFFFFF and increments on every cycle its condition holds:
    - load_stall_cnt: RUN && lu && !branch_taken_ex.
    - div_stall_cnt: DIV_BUSY.
    - flush_cnt: RUN && branch_taken_ex.
  - Counters are cleared by reset.
- Undefined: the ports and counters are absent; control behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - typedef enum logic {RUN, DIV_BUSY} hazard_state_t;
  - localparam NOP_INSTR = 32'h00000013;
  - default DIV_CYCLES.
- One sub-module: load_use_detector, purely combinational, computing lu. It is reused by the stall-count logic.

Test Plan:
1. lw x5 in EX (rd_ex=5, mem_read_ex=1), ID add reads rs1=5 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then all enables 1. Same stimulus with rd_ex=0 -> no stall.
2. Load-use and branch_taken_ex in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1; no stall.
3. DIV_CYCLES=4, is_div_id=1 in RUN:
   - cycle 0: div_start=1.
   - cycles 1-4: div_busy=1, pc_write=0.
   - cycles 1-3: ex_mem_bubble=1; cycle 4: ex_mem_bubble=0.
   - cycle 5: RUN.
4. Two divides back-to-back (DIV_CYCLES=4) -> second div_start exactly 5 cycles after the first; no div_start while div_busy=1.
5. Assert reset during cycle 2 of DIV_BUSY -> next cycle state=RUN, div_busy=0, pc_write=1; a pending is_div_id after reset issues a fresh div_start.
6. With HAZARD_PERF_CNT_EN: 3 load-use stalls, 1 divide (DIV_CYCLES=4), 2 flushes -> load_stall_cnt=3, div_stall_cnt=4, flush_cnt=2.
